// File: rtl/mac_frame_accumulator_pkg.sv
// Shared parameters for the MAC stage and its downstream frame accumulator.
// Both blocks import this package so the MAC latency is defined in one place.
package par_parameter;

    // MAC operand width minus one; the MAC result is 2*par+2 bits wide
    localparam int par = 7;

    // Clock cycles from A/B/C at the MAC input to a valid MAC output
    localparam int MAC_LAT = 3;

    // One MAC result (A*B + C), unsigned
    typedef logic [par*2+1:0] mac_t;

    // Width that holds n_terms maximum-value MAC results without overflow
    function automatic int acc_width(input int n_terms);
        return 2*par + 2 + $clog2(n_terms);
    endfunction

endpackage

// File: rtl/mac_frame_accumulator_if.sv
// Bus between the MAC-side environment and the frame accumulator.
// The master presents MAC results and accepts totals; the slave is the accumulator.
interface mac_frame_accumulator_if
    import par_parameter::*;
#(
    parameter int N_TERMS = 8
);

    localparam int ACC_W = acc_width(N_TERMS);
    localparam int CNT_W = $clog2(N_TERMS);

    logic             src_valid;
    mac_t             mac_out;
    logic [ACC_W-1:0] sum_data;
    logic             sum_valid;
    logic             sum_ready;
    logic [CNT_W-1:0] term_cnt;
    logic             overrun;

    modport master (
        output src_valid,
        output mac_out,
        output sum_ready,
        input  sum_data,
        input  sum_valid,
        input  term_cnt,
        input  overrun
    );

    modport slave (
        input  src_valid,
        input  mac_out,
        input  sum_ready,
        output sum_data,
        output sum_valid,
        output term_cnt,
        output overrun
    );

endinterface

// File: rtl/mac_frame_accumulator_valid_delay.sv
// Shift register that carries the source valid alongside the MAC pipeline,
// since the MAC stage itself has no valid signal.
module valid_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] vld_sr;

    // Shift the valid bit one stage per clock; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign dout = vld_sr[DEPTH-1];

endmodule

// File: rtl/mac_frame_accumulator.sv
// Sums N_TERMS consecutive MAC results into one frame total and presents it
// on a valid/ready output register. Totals that complete while the previous
// one is still unread are dropped and flagged on the sticky overrun bit.
module mac_frame_accumulator
    import par_parameter::*;
#(
    parameter int N_TERMS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    mac_frame_accumulator_if.slave   bus
);

    localparam int ACC_W = acc_width(N_TERMS);
    localparam int CNT_W = $clog2(N_TERMS);
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

    logic             term_v;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] total;
    logic [CNT_W-1:0] cnt;
    logic             frame_end;
    logic [ACC_W-1:0] sum_data_q;
    logic             sum_valid_q;
    logic             overrun_q;

    valid_delay #(
        .DEPTH (MAC_LAT)
    ) u_valid_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.src_valid),
        .dout (term_v)
    );

    assign term      = ACC_W'(bus.mac_out);
    assign total     = acc + term;
    assign frame_end = term_v && (cnt == LAST_TERM);

    // Accumulate aligned MAC results and count terms within the current frame
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (term_v) begin
            acc <= (cnt == '0) ? term : total;
            cnt <= frame_end ? '0 : cnt + 1'b1;
        end
    end

    // Output register: load a finished total if the slot is free or being read
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_data_q  <= '0;
            sum_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (frame_end) begin
            if (!sum_valid_q || bus.sum_ready) begin
                sum_data_q  <= total;
                sum_valid_q <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (sum_valid_q && bus.sum_ready) begin
            sum_valid_q <= 1'b0;
        end
    end

    assign bus.sum_data  = sum_data_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.term_cnt  = cnt;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_mac_frame_accumulator.sv
// Bench for mac_frame_accumulator: drives a behavioural MAC stage and the
// accumulator together, compares every cycle against a frame-level model.
module tb_mac_frame_accumulator;
    import par_parameter::*;

    localparam int N     = 4;
    localparam int ACC_W = acc_width(N);

    logic clk = 1'b0;
    logic rst;
    logic [par:0] op_a, op_b, op_c;
    mac_t s1, s2;

    always #5 clk = ~clk;

    mac_frame_accumulator_if #(.N_TERMS(N)) bus ();

    mac_frame_accumulator #(
        .N_TERMS (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // MAC stage: out = A*B + C, three register stages
    always @(posedge clk) begin
        s1          <= op_a * op_b + mac_t'(op_c);
        s2          <= s1;
        bus.mac_out <= s2;
    end

    // Reference model: terms land MAC_LAT edges after their source edge,
    // are collected into a queue, and every N of them form one total
    int     edge_no = 0;
    int     term_at[int];
    int     frame_q[$];
    longint exp_data  = 0;
    bit     exp_valid = 1'b0;
    bit     exp_overrun = 1'b0;

    always @(posedge clk) begin
        longint frame_total;
        bit     done;
        edge_no++;
        done = 1'b0;
        frame_total = 0;
        if (rst) begin
            term_at.delete();
            frame_q.delete();
            exp_data    = 0;
            exp_valid   = 1'b0;
            exp_overrun = 1'b0;
        end else begin
            if (bus.src_valid)
                term_at[edge_no + MAC_LAT] = int'(op_a) * int'(op_b) + int'(op_c);
            if (term_at.exists(edge_no)) begin
                frame_q.push_back(term_at[edge_no]);
                term_at.delete(edge_no);
                if (frame_q.size() == N) begin
                    foreach (frame_q[i]) frame_total += frame_q[i];
                    frame_q.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!exp_valid || bus.sum_ready) begin
                    exp_data  = frame_total;
                    exp_valid = 1'b1;
                end else begin
                    exp_overrun = 1'b1;
                end
            end else if (exp_valid && bus.sum_ready) begin
                exp_valid = 1'b0;
            end
        end
    end

    int checks_total  = 0;
    int checks_passed = 0;
    int valid_cycles  = 0;
    int last_cnt      = 0;
    int cnt_trace[$];

    task automatic check_val(input string name, input longint act, input longint exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic checkOutput(input string tag);
        check_val({tag, " sum_valid"}, longint'(bus.sum_valid), longint'(exp_valid));
        check_val({tag, " sum_data"},  longint'(bus.sum_data),  exp_data);
        check_val({tag, " term_cnt"},  longint'(bus.term_cnt),  longint'(frame_q.size()));
        check_val({tag, " overrun"},   longint'(bus.overrun),   longint'(exp_overrun));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput("model");
        if (bus.sum_valid) valid_cycles++;
        if (int'(bus.term_cnt) != last_cnt) begin
            last_cnt = int'(bus.term_cnt);
            cnt_trace.push_back(last_cnt);
        end
    endtask

    task automatic applyStimulus(input bit v, input int a, input int b, input int c, input bit ready);
        bus.src_valid = v;
        op_a          = (par+1)'(a);
        op_b          = (par+1)'(b);
        op_c          = (par+1)'(c);
        bus.sum_ready = ready;
        tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        rst = 1'b0;
    endtask

    // Frame 1 = 24, frame 2 = 56, sum_ready low until the second frame-end edge
    task automatic run_two_frames(input bit ready_at_end);
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, i, 2, 1, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, ready_at_end);
    endtask

    typedef struct {
        int a[4];
        int b[4];
        int c;
        int exp_total;
    } frame_vec_t;

    frame_vec_t vecs[4];
    bit gap_pat[7];

    initial begin
        vecs[0] = '{'{1, 2, 3, 4},         '{2, 2, 2, 2},         1,   24};
        vecs[1] = '{'{255, 255, 255, 255}, '{255, 255, 255, 255}, 255, 261120};
        vecs[2] = '{'{0, 0, 0, 0},         '{9, 8, 7, 6},         0,   0};
        vecs[3] = '{'{10, 20, 30, 40},     '{1, 2, 3, 4},         5,   320};
        gap_pat = '{1, 0, 0, 1, 1, 0, 1};

        rst = 1'b1;
        bus.src_valid = 1'b0;
        bus.sum_ready = 1'b0;
        op_a = '0; op_b = '0; op_c = '0;
        tick();
        tick();
        rst = 1'b0;
        check_val("reset sum_data",  longint'(bus.sum_data), 0);
        check_val("reset sum_valid", longint'(bus.sum_valid), 0);
        check_val("reset term_cnt",  longint'(bus.term_cnt), 0);
        check_val("reset overrun",   longint'(bus.overrun), 0);

        $display("[TB] single frames from table, sum_ready held high");
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++)
                applyStimulus(1'b1, vecs[v].a[i], vecs[v].b[i], vecs[v].c, 1'b1);
            applyStimulus(1'b0, 0, 0, 0, 1'b1);
            applyStimulus(1'b0, 0, 0, 0, 1'b1);
            check_val("table early sum_valid", longint'(bus.sum_valid), 0);
            applyStimulus(1'b0, 0, 0, 0, 1'b1);
            check_val("table sum_valid", longint'(bus.sum_valid), 1);
            check_val("table sum_data", longint'(bus.sum_data), longint'(vecs[v].exp_total));
            applyStimulus(1'b0, 0, 0, 0, 1'b1);
            check_val("table one-cycle sum_valid", longint'(bus.sum_valid), 0);
        end

        $display("[TB] back-to-back maximum frames");
        valid_cycles = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 255, 255, 255, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 0, 0, 1'b1);
        check_val("b2b total count", longint'(valid_cycles), 2);
        check_val("b2b sum_data", longint'(bus.sum_data), 261120);
        check_val("b2b overrun", longint'(bus.overrun), 0);

        $display("[TB] frame end coincides with handshake");
        run_two_frames(1'b1);
        check_val("hs sum_valid", longint'(bus.sum_valid), 1);
        check_val("hs sum_data", longint'(bus.sum_data), 56);
        check_val("hs overrun", longint'(bus.overrun), 0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        check_val("hs drop sum_valid", longint'(bus.sum_valid), 0);

        $display("[TB] gapped source valid");
        cnt_trace.delete();
        last_cnt = int'(bus.term_cnt);
        for (int i = 0; i < 7; i++) applyStimulus(gap_pat[i], i + 1, 3, 0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 0, 0, 1'b1);
        check_val("gap trace length", longint'(cnt_trace.size()), 4);
        if (cnt_trace.size() == 4) begin
            check_val("gap cnt step 0", longint'(cnt_trace[0]), 1);
            check_val("gap cnt step 1", longint'(cnt_trace[1]), 2);
            check_val("gap cnt step 2", longint'(cnt_trace[2]), 3);
            check_val("gap cnt step 3", longint'(cnt_trace[3]), 0);
        end
        check_val("gap sum_data", longint'(bus.sum_data), 51);

        $display("[TB] backpressure across second frame end");
        run_two_frames(1'b0);
        check_val("bp sum_valid", longint'(bus.sum_valid), 1);
        check_val("bp held sum_data", longint'(bus.sum_data), 24);
        check_val("bp overrun", longint'(bus.overrun), 1);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        check_val("bp release sum_valid", longint'(bus.sum_valid), 0);
        check_val("bp release sum_data", longint'(bus.sum_data), 24);
        check_val("bp sticky overrun", longint'(bus.overrun), 1);

        $display("[TB] reset with partial frame and term in flight");
        applyStimulus(1'b1, 5, 5, 0, 1'b1);
        applyStimulus(1'b1, 6, 6, 0, 1'b1);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        applyStimulus(1'b1, 7, 7, 0, 1'b1);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        check_val("pre-reset term_cnt", longint'(bus.term_cnt), 2);
        apply_reset();
        check_val("post-reset sum_data",  longint'(bus.sum_data), 0);
        check_val("post-reset sum_valid", longint'(bus.sum_valid), 0);
        check_val("post-reset term_cnt",  longint'(bus.term_cnt), 0);
        check_val("post-reset overrun",   longint'(bus.overrun), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 0, 1'b1);
        check_val("in-flight term discarded", longint'(bus.term_cnt), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3, 3, 0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 0, 1'b1);
        check_val("clean frame sum_valid", longint'(bus.sum_valid), 1);
        check_val("clean frame sum_data", longint'(bus.sum_data), 36);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                apply_reset();
            end else begin
                applyStimulus(($urandom_range(0, 9) < 6),
                              int'($urandom_range(0, 255)),
                              int'($urandom_range(0, 255)),
                              int'($urandom_range(0, 255)),
                              ($urandom_range(0, 1) == 1));
            end
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 0, 0, 0, 1'b1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
